adpt_seg_scan: RTL and testbench
================================

# adpt_seg_scan

Time-multiplexed driver for the board's 8-digit seven-segment display, the output-side counterpart of the switch input adapter. It takes a 32-bit value from the datapath (e.g. adder SUM/C4 packed into nibbles), holds it in a shadow register, and scans it onto active-low anode and segment pins one digit at a time. New values are swapped in only at frame boundaries, so a digit never shows half of one value and half of another.

## Interface
- `CLK_DIV`, default 50000: clock cycles per digit slot; minimum 2.
- `DIGITS`, default 8: number of digits scanned; range 1..8.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  one-cycle strobe; captures `value` and `dp_mask`.
- `value`  in  32  hex value; nibble k drives digit k (digit 0 is rightmost).
- `dp_mask`  in  8  bit k = 1 lights the decimal point of digit k.
- `an_n`  out  8  anode enables, active-low; bits at or above `DIGITS` are always 1.
- `seg_n`  out  7  segments g..a in bits [6:0], active-low.
- `dp_n`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- State registers:
  - `div` counts 0..CLK_DIV-1.
  - `idx` counts 0..DIGITS-1.
  - `pend_val`/`pend_dp` hold a value captured by `load` that is not yet displayed.
  - `act_val`/`act_dp` hold the value being displayed.
  - `pend_vld` is a 1-bit flag.
- Divider: `div` increments every cycle. At CLK_DIV-1 it wraps to 0 and `idx` advances. `idx` wraps from DIGITS-1 to 0.
- Frame boundary: the cycle in which both `div` and `idx` wrap.
- Digit slot of CLK_DIV cycles:
  - Guard cycle (`div`==0): `an_n` all 1, `seg_n`=7'h7F, `dp_n`=1. This prevents ghosting between digits.
  - Remaining cycles: `an_n[idx]`=0, `seg_n`=font(`act_val[4*idx+3:4*idx]`), `dp_n`=~`act_dp[idx]`.
- Font, hex 0..F, active-low: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Load handling:
  - `load` outside a frame boundary: `pend_*` ← inputs and `pend_vld` ← 1. A later `load` before the boundary overwrites the pending value; last one wins.
  - At a frame boundary with `pend_vld`=1 and no `load`: `act_*` ← `pend_*` and `pend_vld` ← 0.
  - `load` in the same cycle as a frame boundary: `act_*` ← inputs directly and `pend_vld` ← 0. The new input wins over any older pending value.
- `frame_done` is asserted for exactly one cycle, registered, in the cycle after the boundary edge, i.e. while the new `act_*` is first visible (`idx`=0, `div`=0).

## Timing
- All outputs are registered from the next-state values of `div`/`idx`/`act_*`, so outputs are coherent with the counters and glitch-free.
- Reset state:
  - `div`=0, `idx`=0, `act_val`=0, `act_dp`=0, `pend_vld`=0.
  - Outputs: `an_n`=8'hFF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0.
- After `rst` falls, digit 0 is enabled first at `div`=1.
- Frame length: DIGITS×CLK_DIV cycles.
- Display latency of a `load`: at most one frame plus one cycle. It is zero extra cycles if the `load` coincides with a boundary.
- `rst` asserted mid-frame: all state returns to reset values on that edge and any pending value is discarded.

## Configuration
- `SEG_LZB_EN` (leading-zero blanking):
  - Defined: every digit k > 0 whose nibble and all higher nibbles of `act_val` are zero shows `seg_n`=7'h7F. `an_n` and `dp_n` still behave as normal, so decimal points stay visible. Digit 0 is never blanked.
  - Undefined: all DIGITS digits always show their hex glyph.

## Structure
- Shared package `seg_pkg`: DIGITS maximum constant (8), font localparam array (16×7, active-low), blank glyph constant 7'h7F.
- One sub-module, `seg_hex_font`: combinational 4-bit nibble → 7-bit `seg_n` lookup.

## Test plan
All scenarios use CLK_DIV=4 and DIGITS=8.
- Reset release with no load: cycle 0 gives `an_n`=FF. Cycles 1–3 give `an_n`=FE and `seg_n`=40. Digit 7 slot is at cycles 29–31. `frame_done` pulses at cycle 32.
- `load` of `value`=32'h0123_89AF with `dp_mask`=8'h01 mid-frame: the old value is shown until the boundary. The next frame shows F,A,9,8,3,2,1,0 on digits 0..7, with `dp_n`=0 only on digit 0.
- Two `load`s in one frame (32'h1111_1111, then 32'h2222_2222): the next frame shows all 2s (`seg_n`=24).
- `load` on the exact boundary cycle with 32'h0000_0005: shown starting at that frame's digit 0 (`seg_n`=12).
- `SEG_LZB_EN` defined with `value`=32'h0000_0050: digits 2..7 show 7F, digit 1 shows 12, digit 0 shows 40. With the macro undefined, digits 2..7 show 40.
- `rst` pulse during digit 4 with a load pending: outputs go to FF/7F/1 on the next edge. The display then restarts at digit 0 showing zeros, and the pending value is never shown.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit limit, hex font
// (active-low, g..a in bits [6:0]) and the all-off glyph.
package seg_pkg;

  localparam int SEG_MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_FONT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_hex_font.sv
// Combinational nibble -> active-low segment lookup.
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_FONT[nib];

endmodule

// File: rtl/adpt_seg_scan.sv
// Multiplexed 8-digit seven-segment scanner with frame-aligned value swap.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module adpt_seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div, div_nx;
  logic [2:0]    idx, idx_nx;
  logic [31:0]   act_val, act_val_nx, pend_val;
  logic [7:0]    act_dp, act_dp_nx, pend_dp;
  logic          pend_vld;
  logic          div_wrap, idx_wrap, boundary;
  logic [3:0]    nib;
  logic [6:0]    font_seg;
  logic          blank;

  always_comb begin
    div_wrap = (div == DW'(CLK_DIV - 1));
    idx_wrap = (idx == 3'(DIGITS - 1));
    boundary = div_wrap && idx_wrap;
    div_nx   = div_wrap ? '0 : div + 1'b1;
    idx_nx   = idx;
    if (div_wrap) idx_nx = idx_wrap ? 3'd0 : idx + 3'd1;

    // A load landing on the boundary bypasses the pending slot entirely.
    act_val_nx = act_val;
    act_dp_nx  = act_dp;
    if (boundary && load) begin
      act_val_nx = value;
      act_dp_nx  = dp_mask;
    end else if (boundary && pend_vld) begin
      act_val_nx = pend_val;
      act_dp_nx  = pend_dp;
    end

    nib = act_val_nx[{idx_nx, 2'b00} +: 4];
  end

`ifdef SEG_LZB_EN
  always_comb begin
    logic hi_zero;
    blank   = 1'b0;
    hi_zero = 1'b1;
    for (int k = SEG_MAX_DIGITS - 1; k >= 1; k--) begin
      hi_zero = hi_zero && (act_val_nx[4*k +: 4] == 4'h0);
      if (idx_nx == 3'(k) && hi_zero) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  seg_hex_font u_font (
    .nib (nib),
    .seg (font_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      idx        <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      an_n       <= 8'hFF;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      div        <= div_nx;
      idx        <= idx_nx;
      act_val    <= act_val_nx;
      act_dp     <= act_dp_nx;
      frame_done <= boundary;

      if (load && !boundary) begin
        pend_val <= value;
        pend_dp  <= dp_mask;
        pend_vld <= 1'b1;
      end else if (boundary) begin
        pend_vld <= 1'b0;
      end

      // Guard cycle at the start of every slot keeps anodes off to avoid ghosting.
      if (div_nx == '0) begin
        an_n  <= 8'hFF;
        seg_n <= SEG_BLANK;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= ~(8'h01 << idx_nx);
        seg_n <= blank ? SEG_BLANK : font_seg;
        dp_n  <= ~act_dp_nx[idx_nx];
      end
    end
  end

endmodule

// File: tb/tb_adpt_seg_scan.sv
// Self-checking bench for adpt_seg_scan (CLK_DIV=4, DIGITS=8) against a
// cycle-count based model of what each digit slot should display.
module tb_adpt_seg_scan;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_done;

  adpt_seg_scan #(.CLK_DIV(4), .DIGITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model: cycles since reset release, shown value, pending value
  int          cyc;
  logic [31:0] m_act, m_pend;
  logic [7:0]  m_adp, m_pdp;
  logic        m_pv;

  function automatic logic [16:0] expect_now();
    int d, i;
    logic [7:0] an;
    logic [6:0] sg;
    logic       dpx, fd;
    logic [31:0] sh;
    d   = cyc % 4;
    i   = (cyc / 4) % 8;
    an  = 8'hFF;
    sg  = 7'h7F;
    dpx = 1'b1;
    fd  = (cyc > 0) && (cyc % 32 == 0);
    if (d != 0) begin
      an = ~(8'h01 << i);
      sh = m_act >> (4 * i);
      sg = font[sh[3:0]];
`ifdef SEG_LZB_EN
      if (i > 0 && sh == 32'h0) sg = 7'h7F;
`endif
      dpx = ~m_adp[i];
    end
    return {an, sg, dpx, fd};
  endfunction

  task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] dm);
    load = ld; value = v; dp_mask = dm;
    @(posedge clk);
    if (cyc % 32 == 31) begin
      if (ld) begin m_act = v; m_adp = dm; end
      else if (m_pv) begin m_act = m_pend; m_adp = m_pdp; end
      m_pv = 1'b0;
    end else if (ld) begin
      m_pend = v; m_pdp = dm; m_pv = 1'b1;
    end
    cyc++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cyc = 0; m_act = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] obs, exp;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    obs = {an_n, seg_n, dp_n, frame_done};
    total++;
    if (obs !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_state got=%h want=%h", obs, {8'hFF, 7'h7F, 1'b1, 1'b0});
    else passed++;
    do_reset();
    for (int c = 0; c < 34; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL reset_scan cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      if (c == 1) begin
        total++;
        if (an_n !== 8'hFE || seg_n !== 7'h40)
          $display("FAIL first_digit an=%h seg=%h want an=fe seg=40", an_n, seg_n);
        else passed++;
      end
      if (c == 30) begin
        total++;
        if (an_n !== 8'h7F) $display("FAIL digit7_slot an=%h want=7f", an_n);
        else passed++;
      end
      if (c == 32) begin
        total++;
        if (frame_done !== 1'b1) $display("FAIL frame_done_32 got=%b want=1", frame_done);
        else passed++;
      end
      step(1'b0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_mid_load();
    logic [16:0] obs, exp;
    int at;
    do_reset();
    at = 32 + $urandom_range(0, 30);
    for (int c = 0; c < 100; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL mid_load cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      if (c == 65) begin
        total++;
        if (seg_n !== 7'h0E || dp_n !== 1'b0)
          $display("FAIL mid_load_d0 seg=%h dp=%b want seg=0e dp=0", seg_n, dp_n);
        else passed++;
      end
      step(c == at, 32'h0123_89AF, 8'h01);
    end
  endtask

  task automatic test_double_load();
    logic [16:0] obs, exp;
    int a1, a2;
    do_reset();
    a1 = 32 + $urandom_range(0, 14);
    a2 = a1 + 1 + $urandom_range(0, 14);
    for (int c = 0; c < 100; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL double_load cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      if (c == 70) begin
        total++;
        if (seg_n !== 7'h24) $display("FAIL double_load_last seg=%h want=24", seg_n);
        else passed++;
      end
      step(c == a1 || c == a2, (c == a1) ? 32'h1111_1111 : 32'h2222_2222, 8'h00);
    end
  endtask

  task automatic test_boundary_load();
    logic [16:0] obs, exp;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL boundary_load cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      if (c == 65) begin
        total++;
        if (seg_n !== 7'h12 || an_n !== 8'hFE)
          $display("FAIL boundary_load_d0 seg=%h an=%h want seg=12 an=fe", seg_n, an_n);
        else passed++;
      end
      step(c == 63, 32'h0000_0005, 8'h00);
    end
  endtask

  task automatic test_lzb();
    logic [16:0] obs, exp;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL lzb cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      if (c == 41) begin
        total++;
`ifdef SEG_LZB_EN
        if (seg_n !== 7'h7F) $display("FAIL lzb_digit2 seg=%h want=7f", seg_n);
`else
        if (seg_n !== 7'h40) $display("FAIL lzb_digit2 seg=%h want=40", seg_n);
`endif
        else passed++;
      end
      if (c == 37) begin
        total++;
        if (seg_n !== 7'h12) $display("FAIL lzb_digit1 seg=%h want=12", seg_n);
        else passed++;
      end
      step(c == 10, 32'h0000_0050, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] obs, exp;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      step(c == 5, 32'hDEAD_BEEF, 8'hFF);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    obs = {an_n, seg_n, dp_n, frame_done};
    total++;
    if (obs !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_mid_out got=%h want=%h", obs, {8'hFF, 7'h7F, 1'b1, 1'b0});
    else passed++;
    rst = 1'b0;
    cyc = 0; m_act = '0; m_adp = '0; m_pv = 1'b0;
    for (int c = 0; c < 70; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL reset_mid_post cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      step(1'b0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_random();
    logic [16:0] obs, exp;
    logic ld;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      obs = {an_n, seg_n, dp_n, frame_done};
      exp = expect_now();
      total++;
      if (obs !== exp) $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp);
      else passed++;
      ld = ($urandom_range(0, 19) == 0) || ((cyc % 32 == 31) && $urandom_range(0, 1) == 1);
      step(ld, $urandom, 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0;
    cyc = 0; m_act = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
    test_reset();
    test_mid_load();
    test_double_load();
    test_boundary_load();
    test_lzb();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
